// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - 16-bit bus-attached ALU with operand/result sequencing FSM
module alu_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic [15:0] bus_in,
  input  logic        alu_in1,
  input  logic        alu_in2,
  input  logic        alu_outlatch,
  input  logic        alu_outen,
  output logic [15:0] bus_out,
  output logic        bus_drive,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_c,
  output logic        flag_v,
  output logic [2:0]  state,
  output logic        proto_err,
  output logic [7:0]  op_count
);

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_A     = 3'd1,
    S_B     = 3'd2,
    S_AB    = 3'd3,
    S_RES   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  state_t      w_base;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_r;

  logic        w_op_valid;
  logic        w_fire;
  logic        w_err;
  logic [16:0] w_sum;
  logic [16:0] w_diff;
  logic [16:0] w_shl;
  logic [16:0] w_shr;
  logic [3:0]  w_shamt;
  logic [15:0] w_res;
  logic        w_c;
  logic        w_v;

  // An operation fires only with both operands present and an arithmetic/logic opcode.
  assign w_op_valid = (opcode >= 4'b1001);
  assign w_fire     = alu_outlatch && (r_state == S_AB) && w_op_valid;
  assign w_err      = (alu_outlatch && !w_fire) || (alu_outen && (r_state != S_RES));

  // Extended-width helpers expose carry/borrow and the last shifted-out bit.
  assign w_shamt = r_b[3:0];
  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
  assign w_shl   = {1'b0, r_a} << w_shamt;
  assign w_shr   = {r_a, 1'b0} >> w_shamt;

  // Result and carry/overflow for the selected opcode, from the pre-edge operands.
  always_comb begin
    w_res = 16'h0000;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (opcode)
      4'b1001: begin
        w_res = w_sum[15:0];
        w_c   = w_sum[16];
        w_v   = (r_a[15] == r_b[15]) && (w_sum[15] != r_a[15]);
      end
      4'b1010: begin
        w_res = w_diff[15:0];
        w_c   = w_diff[16];
        w_v   = (r_a[15] != r_b[15]) && (w_diff[15] != r_a[15]);
      end
      4'b1011: w_res = r_a & r_b;
      4'b1100: w_res = r_a | r_b;
      4'b1101: w_res = r_a ^ r_b;
      4'b1110: begin
        w_res = w_shl[15:0];
        w_c   = w_shl[16];
      end
      4'b1111: begin
        w_res = w_shr[16:1];
        w_c   = w_shr[0];
      end
      default: begin
        w_res = 16'h0000;
        w_c   = 1'b0;
        w_v   = 1'b0;
      end
    endcase
  end

  // Next state: a firing latch moves to S_RES first, then any operand load transitions from there.
  always_comb begin
    w_base = w_fire ? S_RES : r_state;
    w_next = w_base;
    case (w_base)
      S_EMPTY, S_RES: begin
        if (alu_in1 && alu_in2) w_next = S_AB;
        else if (alu_in1)       w_next = S_A;
        else if (alu_in2)       w_next = S_B;
        else                    w_next = w_base;
      end
      S_A:     w_next = alu_in2 ? S_AB : S_A;
      S_B:     w_next = alu_in1 ? S_AB : S_B;
      S_AB:    w_next = S_AB;
      default: w_next = S_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_next;
  end

  // Operand registers load straight from the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= 16'h0000;
      r_b <= 16'h0000;
    end else begin
      if (alu_in1) r_a <= bus_in;
      if (alu_in2) r_b <= bus_in;
    end
  end

  // Result, flags and completed-operation count update only on a firing latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r      <= 16'h0000;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
      op_count <= 8'h00;
    end else if (w_fire) begin
      r_r      <= w_res;
      flag_z   <= (w_res == 16'h0000);
      flag_n   <= w_res[15];
      flag_c   <= w_c;
      flag_v   <= w_v;
      op_count <= op_count + 8'd1;
    end
  end

  // Sticky protocol error: bad latch or bus request without a result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        proto_err <= 1'b0;
    else if (w_err) proto_err <= 1'b1;
  end

  assign state     = r_state;
  assign bus_drive = alu_outen && (r_state == S_RES);
  assign bus_out   = bus_drive ? r_r : 16'h0000;

endmodule

// File: tb/tb_alu_datapath.sv
// tb/tb_alu_datapath.sv - self-checking bench for alu_datapath against a behavioural model
module tb_alu_datapath;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic [15:0] bus_in;
  logic        alu_in1;
  logic        alu_in2;
  logic        alu_outlatch;
  logic        alu_outen;
  logic [15:0] bus_out;
  logic        bus_drive;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        flag_v;
  logic [2:0]  state;
  logic        proto_err;
  logic [7:0]  op_count;

  int n_pass  = 0;
  int n_total = 0;

  // Model: which operands/result are currently "held", plus architectural values.
  bit m_ha, m_hb, m_hr;
  int m_a, m_b, m_r, m_cnt;
  bit m_z, m_n, m_c, m_v, m_err;

  alu_datapath dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .bus_in       (bus_in),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_outlatch (alu_outlatch),
    .alu_outen    (alu_outen),
    .bus_out      (bus_out),
    .bus_drive    (bus_drive),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .flag_c       (flag_c),
    .flag_v       (flag_v),
    .state        (state),
    .proto_err    (proto_err),
    .op_count     (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int m_state();
    if (m_hr)             return 4;
    if (m_ha && m_hb)     return 3;
    if (m_ha)             return 1;
    if (m_hb)             return 2;
    return 0;
  endfunction

  function automatic int to_signed16(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  task automatic ref_alu(input int op, input int a, input int b,
                         output int r, output bit c, output bit v);
    int s;
    int n;
    c = 0;
    v = 0;
    n = b & 15;
    case (op)
      9: begin
        s = a + b;
        r = s & 65535;
        c = ((s >> 16) & 1) != 0;
        s = to_signed16(a) + to_signed16(b);
        v = (s > 32767) || (s < -32768);
      end
      10: begin
        r = (a - b) & 65535;
        c = a < b;
        s = to_signed16(a) - to_signed16(b);
        v = (s > 32767) || (s < -32768);
      end
      11: r = a & b;
      12: r = a | b;
      13: r = a ^ b;
      14: begin
        r = (a << n) & 65535;
        c = (n != 0) && (((a >> (16 - n)) & 1) != 0);
      end
      default: begin
        r = a >> n;
        c = (n != 0) && (((a >> (n - 1)) & 1) != 0);
      end
    endcase
  endtask

  task automatic model_reset();
    m_ha = 0; m_hb = 0; m_hr = 0;
    m_a = 0; m_b = 0; m_r = 0; m_cnt = 0;
    m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit in1, input bit in2, input bit latch, input bit outen,
                            input int op, input int bus);
    int s;
    s = m_state();
    if (latch) begin
      if (s == 3 && op >= 9) begin
        ref_alu(op, m_a, m_b, m_r, m_c, m_v);
        m_z = (m_r == 0);
        m_n = ((m_r >> 15) & 1) != 0;
        m_cnt = (m_cnt + 1) % 256;
        m_hr = 1; m_ha = 0; m_hb = 0;
      end else begin
        m_err = 1;
      end
    end
    if (outen && s != 4) m_err = 1;
    if (in1) begin m_a = bus; m_ha = 1; m_hr = 0; end
    if (in2) begin m_b = bus; m_hb = 1; m_hr = 0; end
  endtask

  task automatic check_regs();
    chk("state",     {29'd0, state},    m_state());
    chk("flag_z",    {31'd0, flag_z},   {31'd0, m_z});
    chk("flag_n",    {31'd0, flag_n},   {31'd0, m_n});
    chk("flag_c",    {31'd0, flag_c},   {31'd0, m_c});
    chk("flag_v",    {31'd0, flag_v},   {31'd0, m_v});
    chk("proto_err", {31'd0, proto_err},{31'd0, m_err});
    chk("op_count",  {24'd0, op_count}, m_cnt);
  endtask

  // One clock: drive inputs, check the combinational bus, clock, update model, check registers.
  task automatic step(input bit in1, input bit in2, input bit latch, input bit outen,
                      input int op, input int bus);
    bit drv;
    alu_in1 = in1; alu_in2 = in2; alu_outlatch = latch; alu_outen = outen;
    opcode = op[3:0]; bus_in = bus[15:0];
    #1;
    drv = outen && (m_state() == 4);
    chk("bus_drive", {31'd0, bus_drive}, {31'd0, drv});
    chk("bus_out",   {16'd0, bus_out},   drv ? m_r : 0);
    @(posedge clk);
    model_edge(in1, in2, latch, outen, op, bus);
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle_inputs();
    alu_in1 = 0; alu_in2 = 0; alu_outlatch = 0; alu_outen = 0;
    opcode = 4'd0; bus_in = 16'd0;
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    idle_inputs();
    #2;
    rst = 1;
    #1;
    model_reset();
    check_regs();
    chk("rst_bus_out",   {16'd0, bus_out},   0);
    chk("rst_bus_drive", {31'd0, bus_drive}, 0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    #3;
    check_regs();
    chk("rst_bus_out", {16'd0, bus_out}, 0);
    @(negedge clk);
    rst = 0;

    // Signed overflow on ADD.
    step(1, 0, 0, 0, 0, 16'h7FFF);
    step(0, 1, 0, 0, 0, 16'h0001);
    step(0, 0, 1, 0, 9, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("add_R", {16'd0, bus_out}, 16'h8000);
    chk("add_nvcz", {28'd0, flag_n, flag_v, flag_c, flag_z}, 4'b1100);
    chk("add_cnt", {24'd0, op_count}, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("reread_R", {16'd0, bus_out}, 16'h8000);

    // SUB with borrow.
    step(1, 0, 0, 0, 0, 16'h0003);
    step(0, 1, 0, 0, 0, 16'h0005);
    step(0, 0, 1, 0, 10, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("sub_R", {16'd0, bus_out}, 16'hFFFE);
    chk("sub_cnv", {29'd0, flag_c, flag_n, flag_v}, 3'b110);

    // SHL carry-out, then zero shift amount.
    step(1, 0, 0, 0, 0, 16'h8001);
    step(0, 1, 0, 0, 0, 16'h0001);
    step(0, 0, 1, 0, 14, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("shl_R", {16'd0, bus_out}, 16'h0002);
    chk("shl_c", {31'd0, flag_c}, 1);
    step(0, 1, 0, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 0, 16'h8001);
    step(0, 0, 1, 0, 14, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("shl0_R", {16'd0, bus_out}, 16'h8001);
    chk("shl0_c", {31'd0, flag_c}, 0);

    // Same-edge latch and reload: result uses the old operands, state goes to S_A.
    step(0, 1, 0, 0, 0, 16'h0010);
    step(0, 0, 1, 0, 9, 0);
    step(1, 0, 0, 0, 0, 16'h0001);
    step(0, 1, 0, 0, 0, 16'h0002);
    step(1, 0, 1, 0, 12, 16'h1234);
    chk("prio_state", {29'd0, state}, 1);
    step(0, 0, 0, 0, 0, 0);

    // Latch with only A loaded.
    async_reset();
    step(1, 0, 0, 0, 0, 16'h00AA);
    step(0, 0, 1, 0, 9, 0);
    chk("latch_err", {31'd0, proto_err}, 1);
    chk("latch_state", {29'd0, state}, 1);
    // Output request while empty.
    async_reset();
    step(0, 0, 0, 1, 0, 0);
    chk("outen_bus", {16'd0, bus_out}, 0);
    chk("outen_err", {31'd0, proto_err}, 1);

    // XOR to zero via dual load, then run the counter round to wrap.
    async_reset();
    step(1, 1, 0, 0, 0, 16'h00F0);
    step(0, 0, 1, 0, 13, 0);
    chk("xor_z", {31'd0, flag_z}, 1);
    for (int i = 0; i < 255; i++) begin
      step(1, 1, 0, 0, 0, $urandom_range(0, 65535));
      step(0, 0, 1, 0, $urandom_range(9, 15), 0);
    end
    chk("wrap_cnt", {24'd0, op_count}, 0);

    // Reset while holding both operands, then latch.
    step(1, 1, 0, 0, 0, 16'h0101);
    chk("pre_rst_state", {29'd0, state}, 3);
    async_reset();
    step(0, 0, 1, 0, 9, 0);
    chk("post_rst_err", {31'd0, proto_err}, 1);

    // Randomized traffic with occasional resets.
    async_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) async_reset();
      step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
           $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
           ($urandom_range(0, 9) < 8) ? $urandom_range(9, 15) : $urandom_range(0, 8),
           $urandom_range(0, 65535));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
